// File: rtl/mdu_pkg.sv
// mdu_pkg: shared constants for the iterative multiply/divide unit.
//   - R-type funct codes handled by the MDU (FN_MFHI .. FN_DIVU)
//   - FSM state encoding (S_IDLE, S_MUL, S_DIV, S_FIX)
//   - is_mdu_op(): true for any funct the MDU recognises
package mdu_pkg;

    localparam logic [5:0] FN_MFHI  = 6'b010000;
    localparam logic [5:0] FN_MTHI  = 6'b010001;
    localparam logic [5:0] FN_MFLO  = 6'b010010;
    localparam logic [5:0] FN_MTLO  = 6'b010011;
    localparam logic [5:0] FN_MULT  = 6'b011000;
    localparam logic [5:0] FN_MULTU = 6'b011001;
    localparam logic [5:0] FN_DIV   = 6'b011010;
    localparam logic [5:0] FN_DIVU  = 6'b011011;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MUL  = 2'd1;
    localparam logic [1:0] S_DIV  = 2'd2;
    localparam logic [1:0] S_FIX  = 2'd3;

    // True when funct selects one of the eight MDU instructions.
    function automatic logic is_mdu_op(input logic [5:0] funct);
        case (funct)
            FN_MFHI, FN_MTHI, FN_MFLO, FN_MTLO,
            FN_MULT, FN_MULTU, FN_DIV, FN_DIVU: return 1'b1;
            default:                            return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mdu_neg.sv
// mdu_neg: combinational conditional two's-complement negate.
// Ports:
//   val   [WIDTH-1:0]  input value
//   neg                 1 = output -val, 0 = pass val through
//   res_c [WIDTH-1:0]  result (combinational)
module mdu_neg #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0] val,
    input  logic             neg,
    output logic [WIDTH-1:0] res_c
);

    assign res_c = neg ? (~val + WIDTH'(1)) : val;

endmodule

// File: rtl/mdu_iter.sv
// mdu_iter: iterative multiply/divide unit with its own funct decoder.
// Owns HI/LO, runs a shift-add multiply or restoring divide over several
// cycles and reports busy/done/stall so control can hold the pipeline.
// Optional build macro: MDU_EARLY_TERM_EN -- multiply stops once the
// remaining multiplier bits are all zero (minimum one step).
// Ports:
//   clk, rst_n        clock (rising edge), async active-low reset
//   valid, funct      MDU instruction strobe and R-type funct field
//   op_a, op_b        rs / rt operand values
//   busy              FSM not idle
//   done              one-cycle pulse after HI/LO written by MULT*/DIV*
//   stall             valid while busy
//   hi, lo            HI / LO registers
//   rd_data           hi for MFHI, lo for MFLO, else 0 (combinational)
module mdu_iter
    import mdu_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             valid,
    input  logic [5:0]       funct,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             busy,
    output logic             done,
    output logic             stall,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] rd_data
);

    localparam int unsigned     CNT_W    = $clog2(WIDTH) + 1;
    localparam int unsigned     DW       = 2 * WIDTH;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    // State and datapath registers.
    // MUL: acc = running product, addend = shifted multiplicand, mplier = remaining multiplier.
    // DIV: acc = {remainder, dividend/quotient}, addend[WIDTH-1:0] = divisor.
    logic [1:0]       state,  state_nxt;
    logic             busy_nxt, done_nxt;
    logic [WIDTH-1:0] hi_nxt, lo_nxt;
    logic [CNT_W-1:0] cnt,    cnt_nxt;
    logic [DW-1:0]    acc,    acc_nxt;
    logic [DW-1:0]    addend, addend_nxt;
    logic [WIDTH-1:0] mplier, mplier_nxt;
    logic             sign_a, sign_a_nxt;
    logic             sign_b, sign_b_nxt;
    logic             op_div, op_div_nxt;
    logic             b_zero, b_zero_nxt;

    // Operand magnitudes for the start cycle; funct[0]=0 marks the signed forms.
    logic             signed_op_c;
    logic             neg_a_c, neg_b_c;
    logic [WIDTH-1:0] abs_a_c, abs_b_c;

    assign signed_op_c = ~funct[0];
    assign neg_a_c     = signed_op_c & op_a[WIDTH-1];
    assign neg_b_c     = signed_op_c & op_b[WIDTH-1];

    mdu_neg #(.WIDTH(WIDTH)) u_abs_a (.val(op_a), .neg(neg_a_c), .res_c(abs_a_c));
    mdu_neg #(.WIDTH(WIDTH)) u_abs_b (.val(op_b), .neg(neg_b_c), .res_c(abs_b_c));

    // Sign fix-up of the unsigned results, used in the FIX cycle.
    logic [DW-1:0]    prod_fix_c;
    logic [WIDTH-1:0] quo_fix_c, rem_fix_c;

    mdu_neg #(.WIDTH(DW)) u_fix_prod (
        .val(acc), .neg(sign_a ^ sign_b), .res_c(prod_fix_c)
    );
    mdu_neg #(.WIDTH(WIDTH)) u_fix_quo (
        .val(acc[WIDTH-1:0]), .neg(sign_a ^ sign_b), .res_c(quo_fix_c)
    );
    mdu_neg #(.WIDTH(WIDTH)) u_fix_rem (
        .val(acc[DW-1:WIDTH]), .neg(sign_a), .res_c(rem_fix_c)
    );

    // Restoring divide step: shift next dividend bit into the remainder, trial-subtract.
    logic [WIDTH:0] div_shift_c, div_trial_c;

    assign div_shift_c = {acc[DW-1:WIDTH], acc[WIDTH-1]};
    assign div_trial_c = div_shift_c - {1'b0, addend[WIDTH-1:0]};

    // Multiply finishes after WIDTH steps, or earlier when nothing is left to add.
    logic mul_last_c;

`ifdef MDU_EARLY_TERM_EN
    assign mul_last_c = (cnt == CNT_LAST) || (mplier[WIDTH-1:1] == '0);
`else
    assign mul_last_c = (cnt == CNT_LAST);
`endif

    // Next-state and datapath update.
    always_comb begin
        state_nxt  = state;
        done_nxt   = 1'b0;
        hi_nxt     = hi;
        lo_nxt     = lo;
        cnt_nxt    = cnt;
        acc_nxt    = acc;
        addend_nxt = addend;
        mplier_nxt = mplier;
        sign_a_nxt = sign_a;
        sign_b_nxt = sign_b;
        op_div_nxt = op_div;
        b_zero_nxt = b_zero;

        case (state)
            S_IDLE: begin
                if (valid && is_mdu_op(funct)) begin
                    case (funct)
                        FN_MTHI: hi_nxt = op_a;
                        FN_MTLO: lo_nxt = op_a;
                        FN_MULT, FN_MULTU: begin
                            acc_nxt    = '0;
                            addend_nxt = {{WIDTH{1'b0}}, abs_a_c};
                            mplier_nxt = abs_b_c;
                            cnt_nxt    = '0;
                            sign_a_nxt = neg_a_c;
                            sign_b_nxt = neg_b_c;
                            op_div_nxt = 1'b0;
                            b_zero_nxt = 1'b0;
                            state_nxt  = S_MUL;
                        end
                        FN_DIV, FN_DIVU: begin
                            acc_nxt    = {{WIDTH{1'b0}}, abs_a_c};
                            addend_nxt = {{WIDTH{1'b0}}, abs_b_c};
                            mplier_nxt = '0;
                            cnt_nxt    = '0;
                            sign_a_nxt = neg_a_c;
                            sign_b_nxt = neg_b_c;
                            op_div_nxt = 1'b1;
                            b_zero_nxt = (op_b == '0);
                            state_nxt  = S_DIV;
                        end
                        default: ;
                    endcase
                end
            end

            S_MUL: begin
                if (mplier[0]) begin
                    acc_nxt = acc + addend;
                end
                addend_nxt = addend << 1;
                mplier_nxt = mplier >> 1;
                cnt_nxt    = cnt + CNT_W'(1);
                if (mul_last_c) begin
                    state_nxt = S_FIX;
                end
            end

            S_DIV: begin
                if (!div_trial_c[WIDTH]) begin
                    acc_nxt = {div_trial_c[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
                end else begin
                    acc_nxt = {div_shift_c[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
                end
                cnt_nxt = cnt + CNT_W'(1);
                if (cnt == CNT_LAST) begin
                    state_nxt = S_FIX;
                end
            end

            S_FIX: begin
                if (op_div) begin
                    // Remainder fix-up already reproduces op_a when dividing by zero.
                    hi_nxt = rem_fix_c;
                    lo_nxt = b_zero ? '1 : quo_fix_c;
                end else begin
                    hi_nxt = prod_fix_c[DW-1:WIDTH];
                    lo_nxt = prod_fix_c[WIDTH-1:0];
                end
                done_nxt  = 1'b1;
                state_nxt = S_IDLE;
            end

            default: state_nxt = S_IDLE;
        endcase

        busy_nxt = (state_nxt != S_IDLE);
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= S_IDLE;
            busy   <= 1'b0;
            done   <= 1'b0;
            hi     <= '0;
            lo     <= '0;
            cnt    <= '0;
            acc    <= '0;
            addend <= '0;
            mplier <= '0;
            sign_a <= 1'b0;
            sign_b <= 1'b0;
            op_div <= 1'b0;
            b_zero <= 1'b0;
        end else begin
            state  <= state_nxt;
            busy   <= busy_nxt;
            done   <= done_nxt;
            hi     <= hi_nxt;
            lo     <= lo_nxt;
            cnt    <= cnt_nxt;
            acc    <= acc_nxt;
            addend <= addend_nxt;
            mplier <= mplier_nxt;
            sign_a <= sign_a_nxt;
            sign_b <= sign_b_nxt;
            op_div <= op_div_nxt;
            b_zero <= b_zero_nxt;
        end
    end

    assign stall = valid & busy;

    // Move-from read port.
    always_comb begin
        rd_data = '0;
        if (funct == FN_MFHI) begin
            rd_data = hi;
        end else if (funct == FN_MFLO) begin
            rd_data = lo;
        end
    end

endmodule

// File: doc/mdu_iter.md
Name: mdu_iter

Overview:
- Parametrised iterative multiply/divide unit with its own funct decoder; successor to the single-cycle ALU decoder path for the multicycle MIPS datapath.
- Decodes MULT/MULTU/DIV/DIVU/MFHI/MFLO/MTHI/MTLO, owns the HI/LO registers and runs a shift-add / restoring-divide FSM.
- Exposes busy/done/stall so control can hold the pipeline.

Parameters:
- WIDTH, 32, operand and HI/LO width (>=4).
- CNT_W, $clog2(WIDTH)+1, iteration counter width (derived localparam).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- valid  in  1  MDU instruction presented this cycle.
- funct  in  6  R-type funct field.
- op_a  in  WIDTH  rs value (multiplicand/dividend, MTHI/MTLO source).
- op_b  in  WIDTH  rt value (multiplier/divisor).
- busy  out  1  FSM not IDLE.
- done  out  1  one-cycle pulse; HI/LO just updated by MULT*/DIV*.
- stall  out  1  = valid & busy.
- hi  out  WIDTH  HI register.
- lo  out  WIDTH  LO register.
- rd_data  out  WIDTH  combinational: hi if funct=MFHI, lo if funct=MFLO, else 0.

Behaviour:
- Reset (async, any state): state=IDLE, hi=lo=0, busy=0, done=0, counter=0, internal accumulators=0.
- Funct codes: MFHI 010000, MTHI 010001, MFLO 010010, MTLO 010011, MULT 011000, MULTU 011001, DIV 011010, DIVU 011011. Any other funct with valid=1 is a no-op.
- States: IDLE, MUL, DIV, FIX.
- IDLE, valid=1:
  - MTHI/MTLO: hi/lo <= op_a at that edge; stays IDLE; no done.
  - MULT*/DIV*: latch |op_a|, |op_b| (raw values for unsigned) and the sign bits; counter=0; go to MUL or DIV.
- MUL: one shift-add step per edge; after WIDTH steps, go to FIX.
- DIV: one restoring shift/subtract step per edge; after WIDTH steps, go to FIX.
- FIX (one edge): apply sign correction, write hi/lo, pulse done=1, return to IDLE.
- Latency: start accepted at edge k; done high for the single cycle after edge k+WIDTH+1; busy high from k+1 through k+WIDTH+1.
- Signed fix-up:
  - product negated if sign_a^sign_b;
  - quotient (lo) negated if sign_a^sign_b;
  - remainder (hi) negated if sign_a.
- Width: product 2*WIDTH bits, hi=upper half, lo=lower half. Unsigned magnitude of the most-negative value is 2^(WIDTH-1).
- Divide by zero (signed or unsigned): lo=all ones, hi=op_a unmodified. Requires no extra cycles and no flag.
- DIV most-negative / -1: lo=most-negative (0x80000000 at 32), hi=0.
- While busy:
  - valid of any funct is ignored and stall=1, including MTHI/MTLO/MFHI/MFLO.
  - hi/lo hold their old values until FIX.
- done and a new valid may coincide: new op accepted at that edge (FSM is in IDLE).

Optional Feature:
- Macro MDU_EARLY_TERM_EN.
- Defined: MUL exits to FIX once the remaining multiplier bits are all zero, minimum 1 step. Iterations = index of highest set bit of |op_b| + 1, so latency = iterations+1 edges to done. Multiplier zero takes 1 iteration. DIV is unchanged.
- Undefined: fixed WIDTH iterations for MUL.

Decomposition:
- Package mdu_pkg holds:
  - funct localparams (FN_MFHI..FN_DIVU);
  - state encoding (S_IDLE, S_MUL, S_DIV, S_FIX);
  - helper function is_mdu_op(funct).
- Sub-module mdu_neg: combinational conditional two's-complement negate (param WIDTH, inputs val, neg). Instantiated for operand abs, product (2*WIDTH), quotient and remainder.

Test Plan (WIDTH=32):
1. MULT op_a=7, op_b=-3 (FFFFFFFD) -> done after 33 edges; hi=FFFFFFFF, lo=FFFFFFEB; busy low with done.
2. MULTU FFFFFFFF*2 -> hi=00000001, lo=FFFFFFFE. Then MFLO rd_data=FFFFFFFE, MFHI rd_data=00000001.
3. DIV -7/2 -> lo=FFFFFFFD, hi=FFFFFFFF. DIVU 100/7 -> lo=0000000E, hi=00000002.
4. DIVU 100/0 -> lo=FFFFFFFF, hi=00000064. DIV 80000000/FFFFFFFF -> lo=80000000, hi=0.
5. MTHI 0xA5 while idle -> hi=000000A5 next edge. MTLO issued while busy -> stall=1, lo unchanged after done.
6. Start MULT, assert rst_n=0 at iteration 10 -> immediately busy=0, hi=lo=0, IDLE. With MDU_EARLY_TERM_EN, MULTU 5*3 -> done after 3 edges, lo=0000000F.
